mux_accum_reg: RTL and testbench
================================

MUX_ACCUM_REG -- requirements
Module: mux_accum_reg

Interface
REQ-001 SHALL have parameter N, default 8: datapath width in bits.
REQ-002 SHALL have parameter M, default 4: number of input channels, M>=2.
REQ-003 SHALL have parameter CW, default 8: burst-length and counter width.
REQ-004 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port clr, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port din, input, M*N: channel k occupies bits [k*N+N-1:k*N].
REQ-007 SHALL have port sel, input, clog2(M): channel select.
REQ-008 SHALL have port en, input, 1: operation/step enable.
REQ-009 SHALL have port op, input, 2: 00 hold, 01 load, 10 add, 11 subtract.
REQ-010 SHALL have port sat, input, 1: 1 = saturating arithmetic, 0 = wrap.
REQ-011 SHALL have port start, input, 1: burst-accumulate request.
REQ-012 SHALL have port len, input, CW: burst sample count.
REQ-013 SHALL have port q, output, N: accumulator register.
REQ-014 SHALL have port carry, output, 1: carry/borrow of the last add/sub.
REQ-015 SHALL have port ovf, output, 1: sticky overflow/underflow flag.
REQ-016 SHALL have port cnt, output, CW: samples accumulated in the current burst.
REQ-017 SHALL have ports busy and done, outputs, 1 each: burst running; one-cycle burst-complete pulse.

Function
REQ-018 SHALL select operand d = din channel sel; sel>=M SHALL give d=0.
REQ-019 SHALL use states IDLE, RUN, DONE; all outputs registered; a result SHALL appear on q the cycle after the enabling edge.
REQ-020 In IDLE with en=1: op 01 SHALL set q=d, carry=0; op 00 SHALL hold q and carry.
REQ-021 Op 10 SHALL compute the unsigned (N+1)-bit sum q+d; carry=bit N; q=low N bits, or all-ones if sat=1 and carry=1.
REQ-022 Op 11 SHALL compute q-d; carry=1 on borrow (d>q); q=low N bits, or 0 if sat=1 and borrow.
REQ-023 ovf SHALL set on any add/sub with carry=1 and hold until clr or an accepted start.
REQ-024 In IDLE, start=1 with len>0 SHALL set q=0, cnt=0, ovf=0, carry=0, latch len, and enter RUN; start SHALL take priority over en/op in that cycle.
REQ-025 In IDLE, start=1 with len=0 SHALL set q=0, cnt=0, ovf=0 and go to DONE.
REQ-026 In RUN, each cycle with en=1 SHALL perform op 10 (add with sat rules) on d and increment cnt; op SHALL be ignored.
REQ-027 In RUN, en=0 SHALL stall: q, cnt, carry, ovf hold.
REQ-028 When an accepted step makes cnt equal to latched len, the next state SHALL be DONE.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE; q, cnt, ovf SHALL hold the final results.
REQ-030 busy SHALL be 1 in RUN and DONE, 0 in IDLE; start SHALL be ignored while busy=1.
REQ-031 len changes after acceptance SHALL have no effect on the running burst.

Reset
REQ-032 clr=1 at a rising edge SHALL force state IDLE, q=0, carry=0, ovf=0, cnt=0, busy=0, done=0, overriding all other inputs including mid-burst.
REQ-033 Reset SHALL be sampled only on clk rising edges; no asynchronous path.

Structure
REQ-034 Op encodings (HOLD, LOAD, ADD, SUB) and state encodings SHALL be declared in shared package mux_accum_pkg.
REQ-035 Channel selection SHALL be one parametrised sub-module muxmg (M-way, N-bit, out-of-range -> 0); arithmetic, FSM and counters SHALL stay in mux_accum_reg.

Verification (N=8, M=4, CW=8)
REQ-036 Load/add wrap: load ch2=0xF0, add ch1=0x20, sat=0 -> q=0x10, carry=1, ovf=1.
REQ-037 Saturation: q=0xF0, add 0x20, sat=1 -> q=0xFF; then sub 0xFF, sat=1 -> q=0x00, carry=0; sub 0x01, sat=1 -> q=0x00, carry=1.
REQ-038 Burst: start, len=3, en high, ch0=5 -> busy 1, q 5/10/15, cnt 1/2/3, done pulses one cycle later, then IDLE with q=15.
REQ-039 Stall/zero-length: burst len=2 with en low two cycles mid-burst -> q, cnt frozen, done delayed two cycles; start len=0 -> q=0, done next cycle.
REQ-040 Reset mid-burst: clr at cnt=1 of len=4 -> next cycle q=0, cnt=0, busy=0, done never asserts; sel=3 out-of-range check with M=3 -> add operand 0.

Source files
------------

// File: rtl/mux_accum_pkg.sv
// mux_accum_pkg
// Shared encodings for the multiplexed accumulator:
//   op_t    - accumulator operation carried on the op input
//   state_t - burst controller states (also visible on state_dbg)
package mux_accum_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muxmg.sv
// muxmg
// M-way, N-bit channel selector. Channel k sits at din[k*N +: N].
// A select value with no matching channel (sel >= M) yields zero.
// Ports:
//   din  - M*N packed channel vector
//   sel  - channel index, clog2(M) bits
//   dout - selected channel, or 0 when out of range
module muxmg #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic [M*N-1:0]         din,
    input  logic [$clog2(M)-1:0]   sel,
    output logic [N-1:0]           dout
);

    localparam int SW = $clog2(M);

    always_comb begin
        dout = '0;
        for (int k = 0; k < M; k++) begin
            if (sel == SW'(k)) begin
                dout = din[k*N +: N];
            end
        end
    end

endmodule

// File: rtl/mux_accum_reg.sv
// mux_accum_reg
// Accumulator fed from one of M input channels, with wrap or saturating
// add/subtract, a sticky overflow flag and a burst-accumulate mode.
// Ports:
//   clk, clr     - clock, synchronous active-high reset
//   din, sel     - packed channels and channel select (sel >= M gives 0)
//   en, op, sat  - step enable, operation (hold/load/add/sub), saturate
//   start, len   - burst request and burst sample count
//   q, carry     - accumulator and carry/borrow of the last add/sub
//   ovf          - sticky overflow/underflow
//   cnt          - samples accumulated in the current burst
//   busy, done   - burst running; one-cycle burst-complete pulse
//   state_dbg    - current controller state (mux_accum_pkg::state_t)
// All outputs are registers; results appear the cycle after the edge.
//
// Handshake: start is a request sampled only while busy=0 (state IDLE);
// it is accepted on that edge, and start/len are ignored while busy=1.
// The burst ends with exactly one cycle of done=1 (state DONE).
module mux_accum_reg
    import mux_accum_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [M*N-1:0]        din,
    input  logic [$clog2(M)-1:0]  sel,
    input  logic                  en,
    input  logic [1:0]            op,
    input  logic                  sat,
    input  logic                  start,
    input  logic [CW-1:0]         len,
    output logic [N-1:0]          q,
    output logic                  carry,
    output logic                  ovf,
    output logic [CW-1:0]         cnt,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic          carry_q, carry_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [N-1:0]  d;
    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [N-1:0]  add_res;
    logic [N-1:0]  sub_res;
    logic [CW-1:0] cnt_inc;

    muxmg #(
        .N (N),
        .M (M)
    ) u_mux (
        .din  (din),
        .sel  (sel),
        .dout (d)
    );

    // Bit N of the widened difference is set exactly when d > q (borrow).
    assign sum     = {1'b0, q_q} + {1'b0, d};
    assign diff    = {1'b0, q_q} - {1'b0, d};
    assign add_res = (sat && sum[N])  ? {N{1'b1}} : sum[N-1:0];
    assign sub_res = (sat && diff[N]) ? {N{1'b0}} : diff[N-1:0];
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A burst request overrides any en/op in the same cycle.
                    q_d     = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    carry_d = 1'b0;
                    len_d   = len;
                    state_d = (len != '0) ? S_RUN : S_DONE;
                end else if (en) begin
                    case (op)
                        OP_LOAD: begin
                            q_d     = d;
                            carry_d = 1'b0;
                        end
                        OP_ADD: begin
                            q_d     = add_res;
                            carry_d = sum[N];
                            ovf_d   = ovf_q | sum[N];
                        end
                        OP_SUB: begin
                            q_d     = sub_res;
                            carry_d = diff[N];
                            ovf_d   = ovf_q | diff[N];
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_RUN: begin
                // Every accepted step is an add; op is not consulted here.
                if (en) begin
                    q_d     = add_res;
                    carry_d = sum[N];
                    ovf_d   = ovf_q | sum[N];
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy/done are registered copies of the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q         = q_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mux_accum_reg.sv
module tb_mux_accum_reg;
    import mux_accum_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    // DUT A: N=8, M=4, CW=8
    logic [31:0] din_a;
    logic [1:0]  sel_a;
    logic        en_a, sat_a, start_a;
    logic [1:0]  op_a;
    logic [7:0]  len_a;
    logic [7:0]  q_a, cnt_a;
    logic        carry_a, ovf_a, busy_a, done_a;
    logic [1:0]  st_a;

    // DUT B: N=8, M=3 (sel=3 is out of range)
    logic [23:0] din_b;
    logic [1:0]  sel_b;
    logic        en_b;
    logic [1:0]  op_b;
    logic [7:0]  q_b, cnt_b;
    logic        carry_b, ovf_b, busy_b, done_b;
    logic [1:0]  st_b;

    int tests  = 0;
    int failed = 0;

    mux_accum_reg #(.N(8), .M(4), .CW(8)) dut_a (
        .clk(clk), .clr(clr), .din(din_a), .sel(sel_a), .en(en_a), .op(op_a),
        .sat(sat_a), .start(start_a), .len(len_a), .q(q_a), .carry(carry_a),
        .ovf(ovf_a), .cnt(cnt_a), .busy(busy_a), .done(done_a), .state_dbg(st_a)
    );

    mux_accum_reg #(.N(8), .M(3), .CW(8)) dut_b (
        .clk(clk), .clr(clr), .din(din_b), .sel(sel_b), .en(en_b), .op(op_b),
        .sat(1'b0), .start(1'b0), .len(8'd0), .q(q_b), .carry(carry_b),
        .ovf(ovf_b), .cnt(cnt_b), .busy(busy_b), .done(done_b), .state_dbg(st_b)
    );

    // driver: advance one edge and sample 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [7:0] eq, input logic ec,
                         input logic eo, input logic [7:0] ecnt, input logic eb,
                         input logic ed);
        chk({tag, ".q"},     q_a,     eq);
        chk({tag, ".carry"}, carry_a, ec);
        chk({tag, ".ovf"},   ovf_a,   eo);
        chk({tag, ".cnt"},   cnt_a,   ecnt);
        chk({tag, ".busy"},  busy_a,  eb);
        chk({tag, ".done"},  done_a,  ed);
    endtask

    initial begin
        clr = 1'b1;
        din_a = 32'h00_F0_20_05; sel_a = 2'd0; en_a = 1'b0; op_a = OP_HOLD;
        sat_a = 1'b0; start_a = 1'b0; len_a = 8'd0;
        din_b = 24'h30_20_10; sel_b = 2'd0; en_b = 1'b0; op_b = OP_HOLD;

        // reset
        tick();
        chk_a("reset", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("reset.state", st_a, S_IDLE);
        chk("reset.qb", q_b, 8'h00);
        clr = 1'b0;

        // load ch2, add ch1 with wrap
        en_a = 1'b1; op_a = OP_LOAD; sel_a = 2'd2; tick();
        chk_a("load", 8'hF0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        op_a = OP_ADD; sel_a = 2'd1; tick();
        chk_a("add_wrap", 8'h10, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        op_a = OP_HOLD; tick();
        chk_a("hold", 8'h10, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        en_a = 1'b0; op_a = OP_ADD; tick();
        chk_a("en_low", 8'h10, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

        // saturation
        en_a = 1'b1; op_a = OP_LOAD; sel_a = 2'd2; tick();
        chk_a("load2", 8'hF0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        op_a = OP_ADD; sel_a = 2'd1; sat_a = 1'b1; tick();
        chk_a("add_sat", 8'hFF, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        din_a = 32'hFF_F0_20_05; op_a = OP_SUB; sel_a = 2'd3; tick();
        chk_a("sub_ff", 8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        din_a = 32'h01_F0_20_05; tick();
        chk_a("sub_sat", 8'h00, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        sat_a = 1'b0; tick();
        chk_a("sub_wrap", 8'hFF, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);

        // burst len=3 on ch0=5; start wins over en/op; ovf cleared
        sel_a = 2'd0; op_a = OP_SUB; en_a = 1'b1; start_a = 1'b1; len_a = 8'd3; tick();
        chk_a("b_start", 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        chk("b_start.state", st_a, S_RUN);
        start_a = 1'b0; len_a = 8'd7; tick();
        chk_a("b_s1", 8'd5, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        start_a = 1'b1; len_a = 8'd0; tick();   // start ignored while busy
        chk_a("b_s2", 8'd10, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
        start_a = 1'b0; tick();
        chk_a("b_s3", 8'd15, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1);
        chk("b_s3.state", st_a, S_DONE);
        tick();
        chk_a("b_idle", 8'd15, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0);
        en_a = 1'b0; op_a = OP_HOLD;

        // stalled burst len=2
        start_a = 1'b1; len_a = 8'd2; tick();
        start_a = 1'b0;
        chk_a("st_start", 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        en_a = 1'b1; tick();
        chk_a("st_s1", 8'd5, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        en_a = 1'b0; tick();
        chk_a("st_hold1", 8'd5, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        tick();
        chk_a("st_hold2", 8'd5, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        en_a = 1'b1; tick();
        chk_a("st_s2", 8'd10, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1);
        en_a = 1'b0; tick();
        chk_a("st_idle", 8'd10, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);

        // zero-length burst
        start_a = 1'b1; len_a = 8'd0; tick();
        start_a = 1'b0;
        chk_a("z_done", 8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
        tick();
        chk_a("z_idle", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // reset mid-burst len=4
        start_a = 1'b1; len_a = 8'd4; tick();
        start_a = 1'b0; en_a = 1'b1; tick();
        chk_a("r_s1", 8'd5, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
        clr = 1'b1; tick();
        clr = 1'b0;
        chk_a("r_clr", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("r_clr.state", st_a, S_IDLE);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("r_after.done", done_a, 1'b0);
            chk("r_after.busy", busy_a, 1'b0);
        end
        en_a = 1'b0;

        // out-of-range select on M=3 instance
        en_b = 1'b1; op_b = OP_LOAD; sel_b = 2'd2; tick();
        chk("b3_load.q", q_b, 8'h30);
        op_b = OP_ADD; sel_b = 2'd3; tick();
        chk("b3_add_oor.q", q_b, 8'h30);
        chk("b3_add_oor.carry", carry_b, 1'b0);
        sel_b = 2'd1; tick();
        chk("b3_add_ch1.q", q_b, 8'h50);
        op_b = OP_LOAD; sel_b = 2'd3; tick();
        chk("b3_load_oor.q", q_b, 8'h00);
        en_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
